// File: rtl/r5p_gpr_dbg.sv
// Debug-side initiator for the R5P GPR file port: executes debug read/write
// commands on the rs1/rd ports while the core is halted, otherwise passes core signals through.
module r5p_gpr_dbg #(
    parameter int unsigned AW   = 5,
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            halted,
    input  logic            en0,
    input  logic            req_vld,
    output logic            req_rdy,
    input  logic            req_wr,
    input  logic [AW-1:0]   req_adr,
    input  logic [XLEN-1:0] req_wdt,
    output logic            rsp_vld,
    input  logic            rsp_rdy,
    output logic [XLEN-1:0] rsp_rdt,
    output logic            rsp_err,
    output logic            own,
    input  logic            c_e_rs1,
    input  logic [AW-1:0]   c_a_rs1,
    input  logic            c_e_rd,
    input  logic [AW-1:0]   c_a_rd,
    input  logic [XLEN-1:0] c_d_rd,
    output logic            e_rs1,
    output logic [AW-1:0]   a_rs1,
    input  logic [XLEN-1:0] d_rs1,
    output logic            e_rd,
    output logic [AW-1:0]   a_rd,
    output logic [XLEN-1:0] d_rd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RSP  = 2'd3
    } state_t;

    state_t          state;
    logic [AW-1:0]   adr;
    logic [XLEN-1:0] wdt;
    logic            reject;

    // A command is refused when the core still owns the port, or on a
    // write to x0 while x0 writes are disabled.
    assign reject  = !halted || (req_wr && (req_adr == '0) && !en0);
    assign req_rdy = (state == IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            adr     <= '0;
            wdt     <= '0;
            rsp_vld <= 1'b0;
            rsp_rdt <= '0;
            rsp_err <= 1'b0;
            own     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_vld) begin
                        adr <= req_adr;
                        wdt <= req_wdt;
                        if (reject) begin
                            state   <= RSP;
                            rsp_vld <= 1'b1;
                            rsp_rdt <= '0;
                            rsp_err <= 1'b1;
                        end else begin
                            state <= req_wr ? WR : RD;
                            own   <= 1'b1;
                        end
                    end
                end
                RD: begin
                    state   <= RSP;
                    own     <= 1'b0;
                    rsp_vld <= 1'b1;
                    rsp_rdt <= d_rs1;
                    rsp_err <= 1'b0;
                end
                WR: begin
                    state   <= RSP;
                    own     <= 1'b0;
                    rsp_vld <= 1'b1;
                    rsp_rdt <= '0;
                    rsp_err <= 1'b0;
                end
                RSP: begin
                    if (rsp_rdy) begin
                        state   <= IDLE;
                        rsp_vld <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    own   <= 1'b0;
                end
            endcase
        end
    end

    // While debug owns the port the core enables are ignored entirely.
    always_comb begin
        e_rs1 = c_e_rs1;
        a_rs1 = c_a_rs1;
        e_rd  = c_e_rd;
        a_rd  = c_a_rd;
        d_rd  = c_d_rd;
        if (own) begin
            e_rs1 = (state == RD);
            a_rs1 = adr;
            e_rd  = (state == WR);
            a_rd  = adr;
            d_rd  = wdt;
        end
    end

endmodule
